// File: rtl/barrett_final_correct.sv
// barrett_final_correct: final correction stage of the Barrett modular multiplier.
// It takes a partial remainder r (expected < 3m) and subtracts m up to twice until
// r < m. The reduced residue, the subtraction count and an error flag are then
// presented on a valid/ready output.
// Optional feature macro: BARRETT_CORR_ERR_EN. When it is defined, the err output
// is driven high if the input violated r < 3m. When it is undefined, err is tied to 0.
module barrett_final_correct #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N+1:0] r_in,
  input  logic [N-1:0] m_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res,
  output logic [1:0]   sub_cnt,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [N+1:0] r_q;
  logic [N-1:0] m_q;
  logic [1:0]   cnt;
  logic [N+1:0] diff;
  logic         no_borrow;
  logic         take_sub;

  // Ripple-carry two's-complement adder; returns {carry_out, sum}
  function automatic logic [N+2:0] rca(input logic [N+1:0] a,
                                       input logic [N+1:0] b,
                                       input logic         c_in);
    logic [N+1:0] s;
    logic         c;
    c = c_in;
    for (int i = 0; i < N + 2; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  // r_q - m_q over N+2 bits with m zero-extended; a carry-out of 1 means r_q >= m_q
  assign {no_borrow, diff} = rca(r_q, ~{2'b00, m_q}, 1'b1);
  assign take_sub = no_borrow && (cnt != 2'd2);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CMP;
      end
      CMP: begin
        if (!take_sub) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iterative subtraction and result latching
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= '0;
      m_q     <= '0;
      cnt     <= '0;
      res     <= '0;
      sub_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r_q <= r_in;
            m_q <= m_in;
            cnt <= 2'd0;
          end
        end
        CMP: begin
          if (take_sub) begin
            r_q <= diff;
            cnt <= cnt + 2'd1;
          end else begin
            res     <= r_q[N-1:0];
            sub_cnt <= cnt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BARRETT_CORR_ERR_EN
  logic err_q;

  // Error flag: decided on the CMP-to-DONE transition, held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (state == CMP && !take_sub) err_q <= no_borrow;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
